// File: rtl/psc_frame_receiver.sv
// PSC link receive stage: K28.5 comma alignment with a HUNT/VERIFY/LOCKED
// state machine, symbol weight checking, and aligned 10-bit symbol delivery.
module psc_frame_receiver #(
  parameter int VERIFY_GAP = 16,
  parameter int LOSS_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  output logic [9:0]  symbol_out,
  output logic        symbol_valid,
  output logic        is_comma,
  output logic        code_error,
  output logic        locked,
  output logic [15:0] error_count
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [9:0]  sr_q, sr_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  bad_q, bad_d;
  logic        offc_q, offc_d;
  logic [9:0]  sym_q, sym_d;
  logic        valid_q, valid_d;
  logic        comma_q, comma_d;
  logic        err_q, err_d;
  logic [15:0] ecnt_q, ecnt_d;

  logic        comma_match;
  logic        boundary;
  logic [3:0]  ones;
  logic        weight_ok;
  logic        emit;
  logic        go_hunt;
  logic [3:0]  bad_n;

  assign comma_match = (sr_q == 10'b0011111010) || (sr_q == 10'b1100000101);
  assign boundary    = (bcnt_q == 4'd9);
  assign weight_ok   = (ones >= 4'd4) && (ones <= 4'd6);

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, sr_q[i]};
    end
  end

  always_comb begin
    sr_d    = {sr_q[8:0], serial_in};
    state_d = state_q;
    bcnt_d  = boundary ? 4'd0 : bcnt_q + 4'd1;
    gap_d   = gap_q;
    bad_d   = bad_q;
    offc_d  = offc_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    comma_d = comma_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    emit    = 1'b0;
    go_hunt = 1'b0;
    bad_n   = bad_q;

    unique case (state_q)
      HUNT: begin
        bcnt_d = 4'd0;
        if (comma_match) begin
          state_d = VERIFY;
          gap_d   = 8'd0;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (comma_match) begin
            state_d = LOCKED;
            emit    = 1'b1;
            bad_d   = 4'd0;
            offc_d  = 1'b0;
          end else if (!weight_ok) begin
            go_hunt = 1'b1;
          end else begin
            gap_d = gap_q + 8'd1;
            if (gap_q + 8'd1 >= 8'(VERIFY_GAP)) go_hunt = 1'b1;
          end
        end else if (comma_match) begin
          go_hunt = 1'b1;
        end
      end
      LOCKED: begin
        // A good symbol only forgives past errors if the phase held since the last boundary.
        if (boundary) begin
          emit   = 1'b1;
          offc_d = 1'b0;
          if (!weight_ok)   bad_n = bad_q + 4'd1;
          else if (!offc_q) bad_n = 4'd0;
        end else if (comma_match) begin
          bad_n  = bad_q + 4'd1;
          offc_d = 1'b1;
        end
        bad_d = bad_n;
        if (bad_n >= 4'(LOSS_LIMIT)) go_hunt = 1'b1;
      end
      default: go_hunt = 1'b1;
    endcase

    if (emit) begin
      sym_d   = sr_q;
      valid_d = 1'b1;
      comma_d = comma_match;
      err_d   = !weight_ok;
      if (!weight_ok && ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
    end

    if (go_hunt) begin
      state_d = HUNT;
      bcnt_d  = 4'd0;
      gap_d   = 8'd0;
      bad_d   = 4'd0;
      offc_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      sr_q    <= 10'd0;
      bcnt_q  <= 4'd0;
      gap_q   <= 8'd0;
      bad_q   <= 4'd0;
      offc_q  <= 1'b0;
      sym_q   <= 10'd0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      bad_q   <= bad_d;
      offc_q  <= offc_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      comma_q <= comma_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign symbol_out   = sym_q;
  assign symbol_valid = valid_q;
  assign is_comma     = comma_q;
  assign code_error   = err_q;
  assign locked       = (state_q == LOCKED);
  assign error_count  = ecnt_q;

endmodule

// File: doc/psc_frame_receiver.md
# psc_frame_receiver

Serial receive stage for the power-supply-controller (PSC) link. It consumes the 1-bit, 10 Mbit/s 8b/10b line that the trigger transmitter's serializer produces, finds K28.5 comma alignment and checks symbol weight. It delivers aligned 10-bit symbols to the downstream 8b/10b decoder and frame/CRC checker. It is used in loopback test builds and in the PSC-side receiver, clocked by the 10 MHz bit clock.

## Interface
- VERIFY_GAP, 16: maximum aligned symbol boundaries in VERIFY without a second comma before returning to HUNT (2..255).
- LOSS_LIMIT, 4: consecutive bad events in LOCKED that force HUNT (1..15).
- clk  in  1  bit clock, 10 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- serial_in  in  1  line bit, sampled every rising edge; first transmitted bit of a symbol lands in symbol bit 9 (MSB-first, abcdeifghj = bits 9..0).
- symbol_out  out  10  last aligned symbol; held between valids.
- symbol_valid  out  1  one-cycle pulse per aligned symbol, LOCKED only.
- is_comma  out  1  qualifies symbol_valid: symbol_out is K28.5.
- code_error  out  1  qualifies symbol_valid: symbol weight outside 4..6 ones.
- locked  out  1  high in LOCKED.
- error_count  out  16  saturating count of code_error pulses since reset.

## Operation
- Shift register sr[9:0] <= {sr[8:0], serial_in} every cycle, all states.
- Comma match: sr == 10'b0011111010 (RD-) or 10'b1100000101 (RD+).
- Weight check: popcount(sr) in {4,5,6} is valid.
- Boundary counter bcnt 0..9, increments mod 10; "boundary" = bcnt == 9.
- HUNT (reset state): comma match at any edge -> bcnt <= 0, go VERIFY, gap counter <= 0. No symbol_valid.
- VERIFY: at boundary with comma -> LOCKED; this comma is emitted (symbol_valid, is_comma). At boundary without comma -> gap counter +1; reaching VERIFY_GAP -> HUNT. Comma match off-boundary, or weight error at boundary -> HUNT.
- LOCKED: every boundary emits sr on symbol_out with symbol_valid. is_comma and code_error are set from that symbol. Bad event = boundary weight error or off-boundary comma match. Bad events increment the consecutive-bad counter. A boundary symbol with valid weight clears the counter, unless an off-boundary comma occurred since the previous boundary. Counter reaching LOSS_LIMIT -> HUNT immediately; locked drops with it.
- Returning to HUNT resets bcnt and all counters except error_count. A comma seen on the exit edge does not re-acquire until the next cycle.
- A comma at a boundary is never an off-boundary event.
- error_count saturates at 16'hFFFF and increments only with code_error.

## Timing
- Reset values: symbol_out 0, symbol_valid 0, is_comma 0, code_error 0, locked 0, error_count 0, state HUNT, sr 0, bcnt 0.
- Latency: the last bit of a symbol is sampled at edge N. symbol_out, symbol_valid, is_comma and code_error update at edge N+1, so the pulse is high for the cycle after N+1.
- Acquisition: comma completes in sr at edge N, and state is VERIFY from N+1. The first boundary is at edge N+10. The earliest locked is at edge N+11 if the next symbol is a comma.
- symbol_valid spacing in LOCKED: exactly 10 cycles, never back-to-back.
- locked falls at the same edge the state leaves LOCKED. No further symbol_valid is issued after that edge.
- Reset mid-symbol or mid-lock: all outputs return to reset values asynchronously. After deassertion, reacquisition starts from HUNT.

## Test plan
- Reset then idle zeros -> outputs at reset values, locked 0, no symbol_valid for 100 cycles.
- Send K28.5 RD-, K28.5 RD+, D21.5 (1010101010), repeated -> locked high 11 cycles after the first comma completes. symbol_valid pulses every 10 cycles with 0x0FA (is_comma), 0x305 (is_comma), 0x2AA.
- Comma followed by 16 non-comma valid symbols (VERIFY_GAP=16) -> returns to HUNT, locked never asserts.
- Locked, then 4 symbols of 1111111111 -> 4 code_error pulses, error_count 4, locked drops at the 4th boundary. 3 bad then 1 good keeps lock.
- Locked, then insert one extra bit (slip) and continue with commas -> off-boundary commas reach LOSS_LIMIT, HUNT, then relock on the new phase.
- Assert reset for 1 cycle while locked mid-symbol -> all outputs 0 immediately. Relock 11 cycles after the next comma completes following deassertion.
